// File: rtl/ahb_master_req_ctrl_pkg.sv
// Shared AHB types for the master request controller: burst/trans encodings,
// response codes and the burst beat-limit helper.
package ahb_master_req_ctrl_pkg;

   typedef enum logic [2:0] {
      BURST_SINGLE = 3'd0,
      BURST_INCR   = 3'd1,
      BURST_WRAP4  = 3'd2,
      BURST_INCR4  = 3'd3,
      BURST_WRAP8  = 3'd4,
      BURST_INCR8  = 3'd5,
      BURST_WRAP16 = 3'd6,
      BURST_INCR16 = 3'd7
   } hburst_type;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'd0,
      TRANS_BUSY   = 2'd1,
      TRANS_NONSEQ = 2'd2,
      TRANS_SEQ    = 2'd3
   } htrans_type;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Index of the final beat; INCR is open-ended so its value is never used.
   function automatic logic [3:0] burst_limit(hburst_type burst);
      logic [3:0] lim;
      case (burst)
         BURST_WRAP4,  BURST_INCR4:  lim = 4'd3;
         BURST_WRAP8,  BURST_INCR8:  lim = 4'd7;
         BURST_WRAP16, BURST_INCR16: lim = 4'd15;
         default:                    lim = 4'd0;
      endcase
      return lim;
   endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational slave-index decode from the top address bits.
module ahb_addr_decode
   import ahb_master_req_ctrl_pkg::*;
#(
   parameter int SLAVE_NUM  = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int SEL_BITS   = 3
) (
   input  logic [ADDR_WIDTH-1:0] haddr,
   output logic [SEL_BITS-1:0]   idx,
   output logic                  mapped
);

   logic unused_addr_bits;

   assign idx              = haddr[ADDR_WIDTH-1 -: SEL_BITS];
   assign mapped           = int'(idx) < SLAVE_NUM;
   assign unused_addr_bits = ^haddr[ADDR_WIDTH-SEL_BITS-1:0];

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// Per-master request controller: raises a one-hot hreq toward the target arbiter,
// stalls the master until granted and tracks burst beats. AHB_MASTER_ERROR_RESP_EN adds the ERROR response.
module ahb_master_req_ctrl
   import ahb_master_req_ctrl_pkg::*;
#(
   parameter int SLAVE_NUM  = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int SEL_BITS   = 3
) (
   input  logic                  hclk,
   input  logic                  hreset_n,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  hburst_type            hburst,
   input  logic [SLAVE_NUM-1:0]  hgrant,
   output logic [SLAVE_NUM-1:0]  hreq,
   output logic                  hready_m,
   output logic                  hresp_m,
   output logic [SEL_BITS-1:0]   slv_idx
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
`ifdef AHB_MASTER_ERROR_RESP_EN
   localparam logic [2:0] ST_ERR1 = 3'd3;
   localparam logic [2:0] ST_ERR2 = 3'd4;
`endif

   logic [2:0]           state;
   logic [3:0]           count;
   logic [3:0]           limit;
   logic                 incr;
   logic [SEL_BITS-1:0]  dec_idx;
   logic                 dec_mapped;
   logic [SLAVE_NUM-1:0] req_vec;
   logic                 grant_sel;
   logic                 is_nonseq;
   logic                 is_active;
   logic                 beat;
   logic                 last;
   logic                 launch;

   ahb_addr_decode #(
      .SLAVE_NUM  (SLAVE_NUM),
      .ADDR_WIDTH (ADDR_WIDTH),
      .SEL_BITS   (SEL_BITS)
   ) u_decode (
      .haddr  (haddr),
      .idx    (dec_idx),
      .mapped (dec_mapped)
   );

   // Loop select avoids indexing past SLAVE_NUM with an over-wide index.
   always_comb begin
      req_vec   = '0;
      grant_sel = 1'b0;
      for (int i = 0; i < SLAVE_NUM; i++) begin
         if (int'(slv_idx) == i) begin
            req_vec[i] = 1'b1;
            grant_sel  = hgrant[i];
         end
      end
   end

   assign is_nonseq = (htrans == TRANS_NONSEQ);
   assign is_active = is_nonseq || (htrans == TRANS_SEQ);
   assign beat      = (state == ST_DATA) && grant_sel && is_active;
   assign last      = (state == ST_DATA) && grant_sel &&
                      (incr ? (htrans == TRANS_IDLE) : (is_active && count == limit));
   assign launch    = is_nonseq && dec_mapped && ((state == ST_IDLE) || last);

   // hreq drops in the last-beat cycle itself so the arbiter can re-arbitrate next edge.
   assign hreq = ((state == ST_REQ) || ((state == ST_DATA) && !last)) ? req_vec : '0;

   always_comb begin
      hready_m = 1'b1;
      case (state)
         ST_REQ:  hready_m = 1'b0;
         ST_DATA: hready_m = grant_sel;
`ifdef AHB_MASTER_ERROR_RESP_EN
         ST_ERR1: hready_m = 1'b0;
`endif
         default: hready_m = 1'b1;
      endcase
   end

`ifdef AHB_MASTER_ERROR_RESP_EN
   assign hresp_m = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
   assign hresp_m = HRESP_OKAY;
`endif

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state   <= ST_IDLE;
         slv_idx <= '0;
         count   <= '0;
         limit   <= '0;
         incr    <= 1'b0;
      end else begin
         if (launch) begin
            slv_idx <= dec_idx;
            limit   <= burst_limit(hburst);
            incr    <= (hburst == BURST_INCR);
         end
         case (state)
            ST_IDLE: begin
               if (launch) state <= ST_REQ;
`ifdef AHB_MASTER_ERROR_RESP_EN
               else if (is_nonseq && !dec_mapped) state <= ST_ERR1;
`endif
            end
            ST_REQ: begin
               if (grant_sel) begin
                  count <= '0;
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (beat && count != 4'hF) count <= count + 4'd1;
               if (last) state <= launch ? ST_REQ : ST_IDLE;
            end
`ifdef AHB_MASTER_ERROR_RESP_EN
            ST_ERR1: state <= ST_ERR2;
            ST_ERR2: state <= ST_IDLE;
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Directed bench for ahb_master_req_ctrl: per-cycle stimulus tables with hand-computed hreq/hready_m/hresp_m.
module tb_ahb_master_req_ctrl;
   import ahb_master_req_ctrl_pkg::*;

   logic        hclk = 1'b0;
   logic        hreset_n;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   hburst_type  hburst;
   logic [3:0]  hgrant;
   logic [3:0]  hreq;
   logic        hready_m;
   logic        hresp_m;
   logic [2:0]  slv_idx;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [1:0]  tr;
      logic [31:0] addr;
      hburst_type  burst;
      logic [3:0]  g;
      logic [3:0]  req;
      logic        rdy;
      logic        resp;
   } vec_t;

   vec_t q[$];

   ahb_master_req_ctrl #(.SLAVE_NUM(4), .ADDR_WIDTH(32), .SEL_BITS(3)) dut (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .haddr    (haddr),
      .htrans   (htrans),
      .hburst   (hburst),
      .hgrant   (hgrant),
      .hreq     (hreq),
      .hready_m (hready_m),
      .hresp_m  (hresp_m),
      .slv_idx  (slv_idx)
   );

   always #5 hclk = ~hclk;

   task automatic add(input logic [1:0] tr, input logic [31:0] addr, input hburst_type burst,
                      input logic [3:0] g, input logic [3:0] req, input logic rdy, input logic resp);
      vec_t v;
      v.tr = tr; v.addr = addr; v.burst = burst; v.g = g;
      v.req = req; v.rdy = rdy; v.resp = resp;
      q.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      @(negedge hclk);
      htrans = v.tr;
      haddr  = v.addr;
      hburst = v.burst;
      hgrant = v.g;
      #1;
   endtask

   task automatic test_reset;
      hreset_n = 1'b0;
      htrans = TRANS_IDLE; haddr = '0; hburst = BURST_SINGLE; hgrant = '0;
      #2;
      vectors++;
      if ({hreq, hready_m, hresp_m, slv_idx} !== {4'b0000, 1'b1, 1'b0, 3'd0}) begin
         miscompares++;
         $display("FAIL reset: hreq/rdy/resp/idx got %b/%b/%b/%0d, want 0000/1/0/0", hreq, hready_m, hresp_m, slv_idx);
      end
      repeat (2) @(negedge hclk);
      hreset_n = 1'b1;
   endtask

   task automatic test_idle_ignore;
      add(TRANS_SEQ,  32'h4000_0000, BURST_INCR4, 4'b0100, 4'b0000, 1'b1, 1'b0);
      add(TRANS_BUSY, 32'h4000_0000, BURST_INCR4, 4'b0100, 4'b0000, 1'b1, 1'b0);
      add(TRANS_IDLE, 32'h4000_0000, BURST_INCR4, 4'b0100, 4'b0000, 1'b1, 1'b0);
      foreach (q[i]) begin
         apply(q[i]);
         vectors++;
         if ({hreq, hready_m, hresp_m} !== {q[i].req, q[i].rdy, q[i].resp}) begin
            miscompares++;
            $display("FAIL idle_ignore[%0d]: hreq/rdy/resp got %b/%b/%b, want %b/%b/%b",
                     i, hreq, hready_m, hresp_m, q[i].req, q[i].rdy, q[i].resp);
         end
      end
      q.delete();
   endtask

   task automatic test_single;
      add(TRANS_NONSEQ, 32'h2000_0000, BURST_SINGLE, 4'b0000, 4'b0000, 1'b1, 1'b0);
      add(TRANS_NONSEQ, 32'h2000_0000, BURST_SINGLE, 4'b0000, 4'b0010, 1'b0, 1'b0);
      add(TRANS_NONSEQ, 32'h2000_0000, BURST_SINGLE, 4'b0010, 4'b0010, 1'b0, 1'b0);
      add(TRANS_SEQ,    32'h2000_0000, BURST_SINGLE, 4'b0010, 4'b0000, 1'b1, 1'b0);
      add(TRANS_IDLE,   32'h0000_0000, BURST_SINGLE, 4'b0000, 4'b0000, 1'b1, 1'b0);
      foreach (q[i]) begin
         apply(q[i]);
         vectors++;
         if ({hreq, hready_m, hresp_m} !== {q[i].req, q[i].rdy, q[i].resp}) begin
            miscompares++;
            $display("FAIL single[%0d]: hreq/rdy/resp got %b/%b/%b, want %b/%b/%b",
                     i, hreq, hready_m, hresp_m, q[i].req, q[i].rdy, q[i].resp);
         end
      end
      q.delete();
      vectors++;
      if (slv_idx !== 3'd1) begin
         miscompares++;
         $display("FAIL single_idx: slv_idx got %0d, want 1", slv_idx);
      end
   endtask

   task automatic test_incr4_stall;
      add(TRANS_NONSEQ, 32'h2000_0000, BURST_INCR4, 4'b0000, 4'b0000, 1'b1, 1'b0);
      add(TRANS_NONSEQ, 32'h2000_0000, BURST_INCR4, 4'b0000, 4'b0010, 1'b0, 1'b0);
      add(TRANS_NONSEQ, 32'h2000_0000, BURST_INCR4, 4'b0010, 4'b0010, 1'b0, 1'b0);
      add(TRANS_SEQ,    32'h2000_0000, BURST_INCR4, 4'b0010, 4'b0010, 1'b1, 1'b0);
      add(TRANS_SEQ,    32'h2000_0000, BURST_INCR4, 4'b0010, 4'b0010, 1'b1, 1'b0);
      add(TRANS_SEQ,    32'h2000_0000, BURST_INCR4, 4'b1101, 4'b0010, 1'b0, 1'b0);
      add(TRANS_SEQ,    32'h2000_0000, BURST_INCR4, 4'b0000, 4'b0010, 1'b0, 1'b0);
      add(TRANS_SEQ,    32'h2000_0000, BURST_INCR4, 4'b0010, 4'b0010, 1'b1, 1'b0);
      add(TRANS_SEQ,    32'h2000_0000, BURST_INCR4, 4'b0010, 4'b0000, 1'b1, 1'b0);
      add(TRANS_IDLE,   32'h0000_0000, BURST_SINGLE, 4'b0000, 4'b0000, 1'b1, 1'b0);
      foreach (q[i]) begin
         apply(q[i]);
         vectors++;
         if ({hreq, hready_m, hresp_m} !== {q[i].req, q[i].rdy, q[i].resp}) begin
            miscompares++;
            $display("FAIL incr4[%0d]: hreq/rdy/resp got %b/%b/%b, want %b/%b/%b",
                     i, hreq, hready_m, hresp_m, q[i].req, q[i].rdy, q[i].resp);
         end
      end
      q.delete();
   endtask

   task automatic test_incr_open;
      add(TRANS_NONSEQ, 32'h6000_0000, BURST_INCR, 4'b0000, 4'b0000, 1'b1, 1'b0);
      add(TRANS_NONSEQ, 32'h6000_0000, BURST_INCR, 4'b0000, 4'b1000, 1'b0, 1'b0);
      add(TRANS_NONSEQ, 32'h6000_0000, BURST_INCR, 4'b1000, 4'b1000, 1'b0, 1'b0);
      add(TRANS_SEQ,    32'h6000_0000, BURST_INCR, 4'b1000, 4'b1000, 1'b1, 1'b0);
      add(TRANS_SEQ,    32'h6000_0000, BURST_INCR, 4'b1000, 4'b1000, 1'b1, 1'b0);
      add(TRANS_BUSY,   32'h6000_0000, BURST_INCR, 4'b1000, 4'b1000, 1'b1, 1'b0);
      add(TRANS_SEQ,    32'h6000_0000, BURST_INCR, 4'b1000, 4'b1000, 1'b1, 1'b0);
      add(TRANS_SEQ,    32'h6000_0000, BURST_INCR, 4'b1000, 4'b1000, 1'b1, 1'b0);
      add(TRANS_SEQ,    32'h6000_0000, BURST_INCR, 4'b1000, 4'b1000, 1'b1, 1'b0);
      add(TRANS_SEQ,    32'h6000_0000, BURST_INCR, 4'b1000, 4'b1000, 1'b1, 1'b0);
      add(TRANS_IDLE,   32'h6000_0000, BURST_INCR, 4'b1000, 4'b0000, 1'b1, 1'b0);
      add(TRANS_IDLE,   32'h0000_0000, BURST_SINGLE, 4'b0000, 4'b0000, 1'b1, 1'b0);
      foreach (q[i]) begin
         apply(q[i]);
         vectors++;
         if ({hreq, hready_m, hresp_m} !== {q[i].req, q[i].rdy, q[i].resp}) begin
            miscompares++;
            $display("FAIL incr_open[%0d]: hreq/rdy/resp got %b/%b/%b, want %b/%b/%b",
                     i, hreq, hready_m, hresp_m, q[i].req, q[i].rdy, q[i].resp);
         end
      end
      q.delete();
   endtask

   task automatic test_back_to_back;
      add(TRANS_NONSEQ, 32'h0000_0000, BURST_WRAP8, 4'b0000, 4'b0000, 1'b1, 1'b0);
      add(TRANS_NONSEQ, 32'h0000_0000, BURST_WRAP8, 4'b0000, 4'b0001, 1'b0, 1'b0);
      add(TRANS_NONSEQ, 32'h0000_0000, BURST_WRAP8, 4'b0001, 4'b0001, 1'b0, 1'b0);
      for (int b = 0; b < 7; b++)
         add(TRANS_SEQ, 32'h0000_0000, BURST_WRAP8, 4'b0001, 4'b0001, 1'b1, 1'b0);
      add(TRANS_NONSEQ, 32'h4000_0000, BURST_SINGLE, 4'b0001, 4'b0000, 1'b1, 1'b0);
      add(TRANS_IDLE,   32'h0000_0000, BURST_SINGLE, 4'b0000, 4'b0100, 1'b0, 1'b0);
      foreach (q[i]) begin
         apply(q[i]);
         vectors++;
         if ({hreq, hready_m, hresp_m} !== {q[i].req, q[i].rdy, q[i].resp}) begin
            miscompares++;
            $display("FAIL b2b[%0d]: hreq/rdy/resp got %b/%b/%b, want %b/%b/%b",
                     i, hreq, hready_m, hresp_m, q[i].req, q[i].rdy, q[i].resp);
         end
      end
      q.delete();
      vectors++;
      if (slv_idx !== 3'd2) begin
         miscompares++;
         $display("FAIL b2b_idx: slv_idx got %0d, want 2", slv_idx);
      end
      add(TRANS_IDLE, 32'h0000_0000, BURST_SINGLE, 4'b0100, 4'b0100, 1'b0, 1'b0);
      add(TRANS_SEQ,  32'h4000_0000, BURST_SINGLE, 4'b0100, 4'b0000, 1'b1, 1'b0);
      add(TRANS_IDLE, 32'h0000_0000, BURST_SINGLE, 4'b0000, 4'b0000, 1'b1, 1'b0);
      foreach (q[i]) begin
         apply(q[i]);
         vectors++;
         if ({hreq, hready_m, hresp_m} !== {q[i].req, q[i].rdy, q[i].resp}) begin
            miscompares++;
            $display("FAIL b2b_tail[%0d]: hreq/rdy/resp got %b/%b/%b, want %b/%b/%b",
                     i, hreq, hready_m, hresp_m, q[i].req, q[i].rdy, q[i].resp);
         end
      end
      q.delete();
   endtask

   task automatic test_unmapped;
      add(TRANS_NONSEQ, 32'hA000_0000, BURST_SINGLE, 4'b0000, 4'b0000, 1'b1, 1'b0);
`ifdef AHB_MASTER_ERROR_RESP_EN
      add(TRANS_IDLE, 32'h0000_0000, BURST_SINGLE, 4'b0000, 4'b0000, 1'b0, 1'b1);
      add(TRANS_IDLE, 32'h0000_0000, BURST_SINGLE, 4'b0000, 4'b0000, 1'b1, 1'b1);
`else
      add(TRANS_IDLE, 32'h0000_0000, BURST_SINGLE, 4'b0000, 4'b0000, 1'b1, 1'b0);
      add(TRANS_IDLE, 32'h0000_0000, BURST_SINGLE, 4'b0000, 4'b0000, 1'b1, 1'b0);
`endif
      add(TRANS_IDLE, 32'h0000_0000, BURST_SINGLE, 4'b0000, 4'b0000, 1'b1, 1'b0);
      foreach (q[i]) begin
         apply(q[i]);
         vectors++;
         if ({hreq, hready_m, hresp_m} !== {q[i].req, q[i].rdy, q[i].resp}) begin
            miscompares++;
            $display("FAIL unmapped[%0d]: hreq/rdy/resp got %b/%b/%b, want %b/%b/%b",
                     i, hreq, hready_m, hresp_m, q[i].req, q[i].rdy, q[i].resp);
         end
      end
      q.delete();
   endtask

   task automatic test_async_reset;
      add(TRANS_NONSEQ, 32'h4000_0000, BURST_INCR16, 4'b0000, 4'b0000, 1'b1, 1'b0);
      add(TRANS_NONSEQ, 32'h4000_0000, BURST_INCR16, 4'b0000, 4'b0100, 1'b0, 1'b0);
      add(TRANS_NONSEQ, 32'h4000_0000, BURST_INCR16, 4'b0100, 4'b0100, 1'b0, 1'b0);
      add(TRANS_SEQ,    32'h4000_0000, BURST_INCR16, 4'b0100, 4'b0100, 1'b1, 1'b0);
      add(TRANS_SEQ,    32'h4000_0000, BURST_INCR16, 4'b0100, 4'b0100, 1'b1, 1'b0);
      foreach (q[i]) begin
         apply(q[i]);
         vectors++;
         if ({hreq, hready_m, hresp_m} !== {q[i].req, q[i].rdy, q[i].resp}) begin
            miscompares++;
            $display("FAIL rst_pre[%0d]: hreq/rdy/resp got %b/%b/%b, want %b/%b/%b",
                     i, hreq, hready_m, hresp_m, q[i].req, q[i].rdy, q[i].resp);
         end
      end
      q.delete();
      @(posedge hclk);
      #2 hreset_n = 1'b0;
      #1;
      vectors++;
      if ({hreq, hready_m, hresp_m, slv_idx} !== {4'b0000, 1'b1, 1'b0, 3'd0}) begin
         miscompares++;
         $display("FAIL rst_async: hreq/rdy/resp/idx got %b/%b/%b/%0d, want 0000/1/0/0", hreq, hready_m, hresp_m, slv_idx);
      end
      @(negedge hclk);
      htrans = TRANS_IDLE; hgrant = '0;
      hreset_n = 1'b1;
      add(TRANS_IDLE, 32'h0000_0000, BURST_SINGLE, 4'b0100, 4'b0000, 1'b1, 1'b0);
      add(TRANS_SEQ,  32'h4000_0000, BURST_INCR16, 4'b0100, 4'b0000, 1'b1, 1'b0);
      foreach (q[i]) begin
         apply(q[i]);
         vectors++;
         if ({hreq, hready_m, hresp_m} !== {q[i].req, q[i].rdy, q[i].resp}) begin
            miscompares++;
            $display("FAIL rst_post[%0d]: hreq/rdy/resp got %b/%b/%b, want %b/%b/%b",
                     i, hreq, hready_m, hresp_m, q[i].req, q[i].rdy, q[i].resp);
         end
      end
      q.delete();
   endtask

   initial begin
      test_reset();
      test_idle_ignore();
      test_single();
      test_incr4_stall();
      test_incr_open();
      test_back_to_back();
      test_unmapped();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
